// File: rtl/depth_idx_gen_pkg.sv
// Shared widths, FSM state type and helpers for the depth index generator.
package depth_idx_gen_pkg;

    localparam int unsigned H_SIZE_BW     = 12;
    localparam int unsigned V_SIZE_BW     = 12;
    localparam int unsigned DATA_DEPTH_BW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } dig_state_e;

    // Inclusive unsigned window test; an inverted window (lo > hi) never matches.
    function automatic logic depth_in_range(
        input logic [DATA_DEPTH_BW-1:0] d,
        input logic [DATA_DEPTH_BW-1:0] lo,
        input logic [DATA_DEPTH_BW-1:0] hi
    );
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/depth_idx_raster_cnt.sv
// Raster position tracker: x/y indices, subsample phases and last-pixel flag.
module depth_idx_raster_cnt
    import depth_idx_gen_pkg::*;
#(
    parameter int unsigned STEP_BW = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic [H_SIZE_BW-1:0] r_width,
    input  logic [V_SIZE_BW-1:0] r_height,
    input  logic [STEP_BW-1:0]   r_step,
    output logic [H_SIZE_BW-1:0] o_x,
    output logic [V_SIZE_BW-1:0] o_y,
    output logic                 o_on_grid_c,
    output logic                 o_last_c
);

    logic [STEP_BW-1:0] px_q;
    logic [STEP_BW-1:0] py_q;
    logic [STEP_BW-1:0] step_m1_c;
    logic               x_wrap_c;

    // Phase wrap point; a zero step behaves like a step of one.
    always_comb begin
        step_m1_c   = (r_step == '0) ? '0 : (r_step - STEP_BW'(1));
        x_wrap_c    = (o_x == (r_width - H_SIZE_BW'(1)));
        o_last_c    = x_wrap_c && (o_y == (r_height - V_SIZE_BW'(1)));
        o_on_grid_c = (px_q == '0) && (py_q == '0);
    end

    // Position and phase counters advance once per accepted pixel beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x  <= '0;
            o_y  <= '0;
            px_q <= '0;
            py_q <= '0;
        end else if (i_clear) begin
            o_x  <= '0;
            o_y  <= '0;
            px_q <= '0;
            py_q <= '0;
        end else if (i_advance) begin
            if (x_wrap_c) begin
                o_x  <= '0;
                px_q <= '0;
                o_y  <= o_y + V_SIZE_BW'(1);
                py_q <= (py_q >= step_m1_c) ? '0 : (py_q + STEP_BW'(1));
            end else begin
                o_x  <= o_x + H_SIZE_BW'(1);
                px_q <= (px_q >= step_m1_c) ? '0 : (px_q + STEP_BW'(1));
            end
        end
    end

endmodule

// File: rtl/depth_idx_gen.sv
// Depth pixel index tagger: raster-tags a depth stream, filters by depth window
// and subsample grid, and emits (x, y, depth) points with per-frame count.
// Optional build macro DEPTH_IDX_GEN_ROI_EN adds a rectangular region of interest.
module depth_idx_gen
    import depth_idx_gen_pkg::*;
#(
    parameter int unsigned STEP_BW = 3,
    parameter int unsigned CNT_BW  = H_SIZE_BW + V_SIZE_BW
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_frame_start,
    input  logic                     i_valid,
    input  logic [DATA_DEPTH_BW-1:0] i_depth,
    input  logic [H_SIZE_BW-1:0]     r_width,
    input  logic [V_SIZE_BW-1:0]     r_height,
    input  logic [STEP_BW-1:0]       r_step,
    input  logic [DATA_DEPTH_BW-1:0] r_depth_min,
    input  logic [DATA_DEPTH_BW-1:0] r_depth_max,
`ifdef DEPTH_IDX_GEN_ROI_EN
    input  logic [H_SIZE_BW-1:0]     r_roi_x0,
    input  logic [H_SIZE_BW-1:0]     r_roi_x1,
    input  logic [V_SIZE_BW-1:0]     r_roi_y0,
    input  logic [V_SIZE_BW-1:0]     r_roi_y1,
`endif
    output logic                     o_valid,
    output logic [H_SIZE_BW-1:0]     o_idx_x,
    output logic [V_SIZE_BW-1:0]     o_idx_y,
    output logic [DATA_DEPTH_BW-1:0] o_depth,
    output logic                     o_frame_done,
    output logic [CNT_BW-1:0]        o_point_cnt,
    output logic                     o_busy
);

    dig_state_e           state_q;
    dig_state_e           state_d;
    logic                 clear_c;
    logic                 advance_c;
    logic                 emit_c;
    logic                 pix_ok_c;
    logic                 roi_ok_c;
    logic                 on_grid_c;
    logic                 last_c;
    logic [H_SIZE_BW-1:0] x_q;
    logic [V_SIZE_BW-1:0] y_q;

    depth_idx_raster_cnt #(
        .STEP_BW (STEP_BW)
    ) u_raster_cnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (clear_c),
        .i_advance   (advance_c),
        .r_width     (r_width),
        .r_height    (r_height),
        .r_step      (r_step),
        .o_x         (x_q),
        .o_y         (y_q),
        .o_on_grid_c (on_grid_c),
        .o_last_c    (last_c)
    );

`ifdef DEPTH_IDX_GEN_ROI_EN
    // Region test uses frame-relative indices; subsample phase is unaffected.
    always_comb begin
        roi_ok_c = (x_q >= r_roi_x0) && (x_q <= r_roi_x1) &&
                   (y_q >= r_roi_y0) && (y_q <= r_roi_y1);
    end
`else
    // Whole frame is eligible.
    always_comb begin
        roi_ok_c = 1'b1;
    end
`endif

    // Pixel qualification independent of FSM state.
    always_comb begin
        pix_ok_c = (i_depth != '0) &&
                   depth_in_range(i_depth, r_depth_min, r_depth_max) &&
                   roi_ok_c;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-beat control; a start pulse always discards a same-cycle beat.
    always_comb begin
        state_d   = state_q;
        clear_c   = 1'b0;
        advance_c = 1'b0;
        emit_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    clear_c = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (i_frame_start) begin
                    clear_c = 1'b1;
                end else if (i_valid) begin
                    advance_c = 1'b1;
                    emit_c    = on_grid_c && pix_ok_c;
                    if (last_c) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered point outputs; index/depth hold between emitted points.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid      <= 1'b0;
            o_idx_x      <= '0;
            o_idx_y      <= '0;
            o_depth      <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_valid      <= emit_c;
            o_frame_done <= (state_q == ST_DONE);
            o_busy       <= (state_d == ST_ACTIVE);
            if (emit_c) begin
                o_idx_x <= x_q;
                o_idx_y <= y_q;
                o_depth <= i_depth;
            end
        end
    end

    // Saturating per-frame point count; holds until the next accepted start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_point_cnt <= '0;
        end else if (clear_c) begin
            o_point_cnt <= '0;
        end else if (emit_c && !(&o_point_cnt)) begin
            o_point_cnt <= o_point_cnt + CNT_BW'(1);
        end
    end

endmodule

// File: tb/tb_depth_idx_gen.sv
// Directed bench for depth_idx_gen; points are captured on the falling edge.
module tb_depth_idx_gen;
    import depth_idx_gen_pkg::*;

    localparam int unsigned STEP_BW = 3;
    localparam int unsigned CNT_BW  = H_SIZE_BW + V_SIZE_BW;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic                     i_frame_start = 1'b0;
    logic                     i_valid = 1'b0;
    logic [DATA_DEPTH_BW-1:0] i_depth = '0;
    logic [H_SIZE_BW-1:0]     r_width = '0;
    logic [V_SIZE_BW-1:0]     r_height = '0;
    logic [STEP_BW-1:0]       r_step = '0;
    logic [DATA_DEPTH_BW-1:0] r_depth_min = '0;
    logic [DATA_DEPTH_BW-1:0] r_depth_max = '0;
`ifdef DEPTH_IDX_GEN_ROI_EN
    logic [H_SIZE_BW-1:0]     r_roi_x0 = '0;
    logic [H_SIZE_BW-1:0]     r_roi_x1 = '1;
    logic [V_SIZE_BW-1:0]     r_roi_y0 = '0;
    logic [V_SIZE_BW-1:0]     r_roi_y1 = '1;
`endif
    logic                     o_valid;
    logic [H_SIZE_BW-1:0]     o_idx_x;
    logic [V_SIZE_BW-1:0]     o_idx_y;
    logic [DATA_DEPTH_BW-1:0] o_depth;
    logic                     o_frame_done;
    logic [CNT_BW-1:0]        o_point_cnt;
    logic                     o_busy;

    depth_idx_gen #(
        .STEP_BW (STEP_BW),
        .CNT_BW  (CNT_BW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_frame_start (i_frame_start),
        .i_valid       (i_valid),
        .i_depth       (i_depth),
        .r_width       (r_width),
        .r_height      (r_height),
        .r_step        (r_step),
        .r_depth_min   (r_depth_min),
        .r_depth_max   (r_depth_max),
`ifdef DEPTH_IDX_GEN_ROI_EN
        .r_roi_x0      (r_roi_x0),
        .r_roi_x1      (r_roi_x1),
        .r_roi_y0      (r_roi_y0),
        .r_roi_y1      (r_roi_y1),
`endif
        .o_valid       (o_valid),
        .o_idx_x       (o_idx_x),
        .o_idx_y       (o_idx_y),
        .o_depth       (o_depth),
        .o_frame_done  (o_frame_done),
        .o_point_cnt   (o_point_cnt),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned last_v_cyc = 0;
    logic [39:0] got_q[$];
    logic [39:0] exp_q[$];

    // Cycle counter.
    always @(posedge i_clk) cyc++;

    // Output monitor: record emitted points and frame-done pulses.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1) begin
            if (o_valid === 1'b1) begin
                got_q.push_back({o_idx_x, o_idx_y, o_depth});
                last_v_cyc = cyc;
            end
            if (o_frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic pix(input logic [DATA_DEPTH_BW-1:0] d);
        i_valid = 1'b1;
        i_depth = d;
        tick(1);
        i_valid = 1'b0;
    endtask

    task automatic start(input logic with_beat);
        i_frame_start = 1'b1;
        i_valid       = with_beat;
        i_depth       = 16'd999;
        tick(1);
        i_frame_start = 1'b0;
        i_valid       = 1'b0;
    endtask

    task automatic cfg(input int w, input int h, input int s, input int mn, input int mx);
        r_width     = H_SIZE_BW'(w);
        r_height    = V_SIZE_BW'(h);
        r_step      = STEP_BW'(s);
        r_depth_min = DATA_DEPTH_BW'(mn);
        r_depth_max = DATA_DEPTH_BW'(mx);
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    function automatic logic [39:0] pt(input int x, input int y, input int d);
        return {H_SIZE_BW'(x), V_SIZE_BW'(y), DATA_DEPTH_BW'(d)};
    endfunction

    task automatic chk_pts(input string tag);
        int n;
        chk({tag, "_npts"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_pt%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_cnt", 64'(o_point_cnt), 64'd0);
        chk("rst_done", 64'(o_frame_done), 64'd0);
        chk("rst_idx", 64'({o_idx_x, o_idx_y, o_depth}), 64'd0);
        i_rst_n = 1'b1;
        tick(2);

        // Beats in IDLE are ignored
        cfg(4, 2, 1, 1, 65535);
        for (int i = 0; i < 4; i++) pix(16'd77);
        tick(3);
        chk_pts("idle");
        chk("idle_busy", 64'(o_busy), 64'd0);

        // Basic raster
        cfg(4, 2, 1, 1, 65535);
        start(1'b0);
        chk("basic_busy", 64'(o_busy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            pix(16'd100);
            exp_q.push_back(pt(i % 4, i / 4, 100));
        end
        tick(4);
        chk_pts("basic");
        chk("basic_done_n", 64'(done_cnt), 64'd1);
        chk("basic_done_lat", 64'(done_cyc - last_v_cyc), 64'd1);
        chk("basic_cnt", 64'(o_point_cnt), 64'd8);
        chk("basic_busy_end", 64'(o_busy), 64'd0);

        // Depth window filter
        cfg(4, 1, 1, 100, 1000);
        start(1'b0);
        pix(16'd0); pix(16'd50); pix(16'd500); pix(16'd5000);
        exp_q.push_back(pt(2, 0, 500));
        tick(4);
        chk_pts("dfilt");
        chk("dfilt_cnt", 64'(o_point_cnt), 64'd1);

        // Subsample step 2 with input gaps
        cfg(5, 3, 2, 1, 65535);
        start(1'b0);
        for (int i = 0; i < 15; i++) begin
            tick(i % 3);
            pix(DATA_DEPTH_BW'(1000 + i));
        end
        for (int y = 0; y < 3; y += 2)
            for (int x = 0; x < 5; x += 2)
                exp_q.push_back(pt(x, y, 1000 + y * 5 + x));
        tick(4);
        chk_pts("sub");
        chk("sub_cnt", 64'(o_point_cnt), 64'd6);
        chk("sub_done_n", 64'(done_cnt), 64'd1);

        // Step 0 behaves as step 1
        cfg(3, 1, 0, 1, 65535);
        start(1'b0);
        for (int i = 0; i < 3; i++) begin
            pix(16'd7);
            exp_q.push_back(pt(i, 0, 7));
        end
        tick(4);
        chk_pts("step0");

        // Restart mid-frame, with a beat alongside the restart pulse
        cfg(4, 4, 1, 1, 65535);
        start(1'b0);
        for (int i = 0; i < 6; i++) begin
            pix(16'd200);
            exp_q.push_back(pt(i % 4, i / 4, 200));
        end
        start(1'b1);
        chk("rst_mid_cnt0", 64'(o_point_cnt), 64'd0);
        chk("rst_mid_busy", 64'(o_busy), 64'd1);
        for (int i = 0; i < 16; i++) begin
            pix(16'd300);
            exp_q.push_back(pt(i % 4, i / 4, 300));
            if (i == 14) chk("rst_mid_nodone", 64'(done_cnt), 64'd0);
        end
        tick(4);
        chk_pts("restart");
        chk("restart_done_n", 64'(done_cnt), 64'd1);
        chk("restart_cnt", 64'(o_point_cnt), 64'd16);

        // Inverted window emits nothing; start pulse during DONE is ignored
        cfg(2, 1, 1, 500, 100);
        start(1'b0);
        pix(16'd300);
        pix(16'd300);
        start(1'b0);
        chk("done_start_busy", 64'(o_busy), 64'd0);
        tick(3);
        chk_pts("inv");
        chk("inv_done_n", 64'(done_cnt), 64'd1);
        chk("inv_cnt", 64'(o_point_cnt), 64'd0);
        chk("inv_busy", 64'(o_busy), 64'd0);

        // Asynchronous reset mid-frame
        cfg(4, 2, 1, 1, 65535);
        start(1'b0);
        pix(16'd100); pix(16'd100); pix(16'd100);
        chk("arst_pre_valid", 64'(o_valid), 64'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_idx", 64'({o_idx_x, o_idx_y, o_depth}), 64'd0);
        chk("arst_cnt", 64'(o_point_cnt), 64'd0);
        chk("arst_busy", 64'(o_busy), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick(1);
        cfg(4, 2, 1, 1, 65535);
        pix(16'd100); pix(16'd100);
        tick(2);
        chk_pts("arst_idle");

        // Start with a same-cycle beat from IDLE: that beat is dropped
        cfg(4, 2, 1, 1, 65535);
        start(1'b1);
        for (int i = 0; i < 8; i++) begin
            pix(DATA_DEPTH_BW'(10 + i));
            exp_q.push_back(pt(i % 4, i / 4, 10 + i));
        end
        tick(4);
        chk_pts("idle_start");
        chk("idle_start_done", 64'(done_cnt), 64'd1);

`ifdef DEPTH_IDX_GEN_ROI_EN
        // Region of interest
        cfg(8, 8, 1, 1, 65535);
        r_roi_x0 = 12'd2;
        r_roi_x1 = 12'd3;
        r_roi_y0 = 12'd5;
        r_roi_y1 = 12'd5;
        start(1'b0);
        for (int i = 0; i < 64; i++) pix(16'd400);
        exp_q.push_back(pt(2, 5, 400));
        exp_q.push_back(pt(3, 5, 400));
        tick(4);
        chk_pts("roi");
        chk("roi_cnt", 64'(o_point_cnt), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
